// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ceiling log2 with a floor of 1 so a single-nibble adder still has a count bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice: generate/propagate carries, exposing c3 for overflow detection.
module cla4_slice
   import nsa_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                c3,
   output logic                c4
);

   logic [NIBBLE_W-1:0] p;
   logic [NIBBLE_W-1:0] g;
   logic [NIBBLE_W:0]   c;

   assign p = a | b;
   assign g = a & b;

   // Every carry is a flat sum of products of g/p and cin.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign sum = (a ^ b) ^ c[NIBBLE_W-1:0];
   assign c3  = c[3];
   assign c4  = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a CLA slice, LSB first,
// with valid/ready handshakes on operand and result sides.
module nibble_serial_adder
   import nsa_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_overflow,
   output logic             busy
);

   localparam int unsigned NIB   = WIDTH / NIBBLE_W;
   localparam int unsigned CNT_W = clog2(NIB);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    count;
   logic                carry;
   logic [WIDTH-1:0]    a_reg;
   logic [WIDTH-1:0]    b_reg;
   logic [WIDTH-1:0]    result;
   logic                cout_reg;
   logic                ovf_reg;

   logic                accept_c;
   logic                handshake_c;
   logic                last_c;
   logic [NIBBLE_W-1:0] nib_a;
   logic [NIBBLE_W-1:0] nib_b;
   logic [NIBBLE_W-1:0] s_sum;
   logic                s_c3;
   logic                s_c4;

   assign accept_c    = (state == IDLE) && in_valid;
   assign handshake_c = (state == DONE) && out_ready;
   assign last_c      = (count == LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_c)    state_nxt = RUN;
         RUN:     if (last_c)      state_nxt = DONE;
         DONE:    if (handshake_c) state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // Handshake/status outputs decoded from the state register.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         RUN:     busy      = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: in_ready  = 1'b0;
      endcase
   end

   // Select the operand nibbles for the current step.
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int i = 0; i < int'(NIB); i++) begin
         if (count == CNT_W'(i)) begin
            nib_a = a_reg[i*NIBBLE_W +: NIBBLE_W];
            nib_b = b_reg[i*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   cla4_slice u_slice (
      .a   (nib_a),
      .b   (nib_b),
      .cin (carry),
      .sum (s_sum),
      .c3  (s_c3),
      .c4  (s_c4)
   );

   // Datapath: operand capture on accept, one nibble per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         carry    <= 1'b0;
         a_reg    <= '0;
         b_reg    <= '0;
         result   <= '0;
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  a_reg    <= in_a;
                  b_reg    <= in_b;
                  carry    <= in_cin;
                  count    <= '0;
                  result   <= '0;
                  cout_reg <= 1'b0;
                  ovf_reg  <= 1'b0;
               end
            end
            RUN: begin
               for (int i = 0; i < int'(NIB); i++) begin
                  if (count == CNT_W'(i)) result[i*NIBBLE_W +: NIBBLE_W] <= s_sum;
               end
               carry <= s_c4;
               if (last_c) begin
                  count    <= '0;
                  cout_reg <= s_c4;
                  ovf_reg  <= s_c4 ^ s_c3;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign out_sum      = result;
   assign out_cout     = cout_reg;
   assign out_overflow = ovf_reg;

endmodule
